branch_history_update: RTL and testbench

Writer side of the branch history table. Tracks every predicted branch from fetch until the execute stage resolves it. On resolution it computes the next 2-bit saturating counter value and drives a registered write port into the table. It also flags mispredictions to the pipeline flush logic. It sits between the fetch stage (push side), the execute stage (resolve side) and the table's write port.

---
 rtl/bht_pkg.sv | 23 ++
 rtl/bht_inflight_fifo.sv | 72 +++++++
 rtl/branch_history_update.sv | 84 ++++++++
 tb/tb_branch_history_update.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// Shared definitions for the branch history table: 2-bit saturating counter
// encoding and its next-state function.
package bht_pkg;

  typedef logic [1:0] bht_state_t;

  localparam bht_state_t ST_STRONG_NT = 2'b00;
  localparam bht_state_t ST_WEAK_NT   = 2'b01;
  localparam bht_state_t ST_WEAK_T    = 2'b10;
  localparam bht_state_t ST_STRONG_T  = 2'b11;

  function automatic bht_state_t sat_next(input bht_state_t state, input logic taken);
    bht_state_t nxt;
    nxt = state;
    if (taken) begin
      if (state != ST_STRONG_T) nxt = state + 2'b01;
    end else begin
      if (state != ST_STRONG_NT) nxt = state - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bht_inflight_fifo.sv
// In-order store of predicted branches {addr, state} awaiting resolution, with
// a broadcast port that rewrites the state of every entry matching an index.
module bht_inflight_fifo
  import bht_pkg::*;
#(
  parameter int LOWER = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     push_en,
  input  logic [LOWER-1:0]         push_addr,
  input  logic [1:0]               push_state,
  input  logic                     pop_en,
  input  logic                     flush,
  input  logic                     fwd_en,
  input  logic [LOWER-1:0]         fwd_addr,
  input  logic [1:0]               fwd_state,
  output logic [LOWER-1:0]         head_addr,
  output logic [1:0]               head_state,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [LOWER-1:0] mem_addr  [DEPTH];
  bht_state_t       mem_state [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  assign head_addr  = mem_addr[rd_ptr];
  assign head_state = mem_state[rd_ptr];
  assign empty      = (count == '0);
  assign full       = (count == CNT_W'(DEPTH));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (flush) begin
        // Everything behind the popped head is wrong-path work.
        rd_ptr <= wr_ptr;
        count  <= '0;
      end else begin
        if (pop_en) rd_ptr <= rd_ptr + 1'b1;
        case ({push_en, pop_en})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Storage carries no reset; only entries between the pointers are meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (fwd_en && (mem_addr[i] == fwd_addr)) mem_state[i] <= fwd_state;
    end
    if (push_en) begin
      mem_addr[wr_ptr]  <= push_addr;
      mem_state[wr_ptr] <= (fwd_en && (push_addr == fwd_addr)) ? fwd_state : push_state;
    end
  end

endmodule

// File: rtl/branch_history_update.sv
// Branch history table writer: resolves in-flight predictions, issues the
// registered counter write and flags mispredictions.
module branch_history_update
  import bht_pkg::*;
#(
  parameter int LOWER = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     push_valid,
  input  logic [LOWER-1:0]         push_addr,
  input  logic [1:0]               push_state,
  output logic                     push_ready,
  input  logic                     resolve_valid,
  input  logic                     was_taken,
  input  logic                     jumped,
  output logic                     upd_en,
  output logic [LOWER-1:0]         upd_addr,
  output logic [1:0]               upd_state,
  output logic                     mispredict,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     resolve_err
);

  logic [LOWER-1:0] head_addr;
  logic [1:0]       head_state;
  logic             empty;
  logic             full;
  logic             outcome_p0;
  logic             resolve_p0;
  logic             mis_p0;
  logic             push_en_p0;
  bht_state_t       new_state_p0;

  assign outcome_p0   = was_taken | jumped;
  assign resolve_p0   = resolve_valid && !empty;
  assign new_state_p0 = sat_next(head_state, outcome_p0);
  assign mis_p0       = resolve_p0 && (head_state[1] != outcome_p0);
  assign push_ready   = !full || resolve_p0;
  // A push racing a flush is wrong-path; fetch is not stalled but it is dropped.
  assign push_en_p0   = push_valid && push_ready && !mis_p0;

  bht_inflight_fifo #(
    .LOWER (LOWER),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .arst_n     (arst_n),
    .push_en    (push_en_p0),
    .push_addr  (push_addr),
    .push_state (push_state),
    .pop_en     (resolve_p0),
    .flush      (mis_p0),
    .fwd_en     (resolve_p0),
    .fwd_addr   (head_addr),
    .fwd_state  (new_state_p0),
    .head_addr  (head_addr),
    .head_state (head_state),
    .empty      (empty),
    .full       (full),
    .count      (count)
  );

  // p0 -> p1: registered table write and mispredict pulse
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      upd_en      <= 1'b0;
      upd_addr    <= '0;
      upd_state   <= ST_STRONG_NT;
      mispredict  <= 1'b0;
      resolve_err <= 1'b0;
    end else begin
      upd_en     <= resolve_p0;
      mispredict <= mis_p0;
      if (resolve_p0) begin
        upd_addr  <= head_addr;
        upd_state <= new_state_p0;
      end
      if (resolve_valid && empty) resolve_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_history_update.sv
// Directed bench for branch_history_update with hand-computed expectations.
module tb_branch_history_update;

  localparam int LOWER = 5;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             arst_n;
  logic             push_valid;
  logic [LOWER-1:0] push_addr;
  logic [1:0]       push_state;
  logic             push_ready;
  logic             resolve_valid;
  logic             was_taken;
  logic             jumped;
  logic             upd_en;
  logic [LOWER-1:0] upd_addr;
  logic [1:0]       upd_state;
  logic             mispredict;
  logic [2:0]       count;
  logic             resolve_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_history_update #(.LOWER(LOWER), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .push_valid    (push_valid),
    .push_addr     (push_addr),
    .push_state    (push_state),
    .push_ready    (push_ready),
    .resolve_valid (resolve_valid),
    .was_taken     (was_taken),
    .jumped        (jumped),
    .upd_en        (upd_en),
    .upd_addr      (upd_addr),
    .upd_state     (upd_state),
    .mispredict    (mispredict),
    .count         (count),
    .resolve_err   (resolve_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic pv, input logic [LOWER-1:0] pa, input logic [1:0] ps,
                        input logic rv, input logic wt, input logic jp);
    push_valid    = pv;
    push_addr     = pa;
    push_state    = ps;
    resolve_valid = rv;
    was_taken     = wt;
    jumped        = jp;
  endtask

  // Apply inputs for one clock, then idle them and sample 1ns after the edge.
  task automatic cyc(input logic pv, input logic [LOWER-1:0] pa, input logic [1:0] ps,
                     input logic rv, input logic wt, input logic jp);
    set_in(pv, pa, ps, rv, wt, jp);
    @(posedge clk);
    #1;
    set_in(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_upd(input string tag, input logic en, input logic [LOWER-1:0] a,
                           input logic [1:0] s, input logic m, input logic [2:0] c);
    check_eq({tag, ".upd_en"}, 32'(upd_en), 32'(en));
    if (en) begin
      check_eq({tag, ".upd_addr"}, 32'(upd_addr), 32'(a));
      check_eq({tag, ".upd_state"}, 32'(upd_state), 32'(s));
    end
    check_eq({tag, ".mispredict"}, 32'(mispredict), 32'(m));
    check_eq({tag, ".count"}, 32'(count), 32'(c));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_in(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b0);
    arst_n = 1'b0;
    #12;
    check_upd("reset", 1'b0, '0, 2'b00, 1'b0, 3'd0);
    check_eq("reset.upd_addr", 32'(upd_addr), 32'd0);
    check_eq("reset.upd_state", 32'(upd_state), 32'd0);
    check_eq("reset.resolve_err", 32'(resolve_err), 32'd0);
    check_eq("reset.push_ready", 32'(push_ready), 32'd1);
    arst_n = 1'b1;
    @(posedge clk); #1;

    // Basic: weak NT predicted, taken -> 10 with mispredict
    cyc(1, 5'd3, 2'b01, 0, 0, 0);
    check_eq("t1.count_push", 32'(count), 32'd1);
    cyc(0, '0, 2'b00, 1, 1, 0);
    check_upd("t1.res", 1'b1, 5'd3, 2'b10, 1'b1, 3'd0);
    cyc(0, '0, 2'b00, 0, 0, 0);
    check_upd("t1.idle", 1'b0, '0, 2'b00, 1'b0, 3'd0);

    // Saturation both directions
    cyc(1, 5'd7, 2'b11, 0, 0, 0);
    cyc(0, '0, 2'b00, 1, 1, 0);
    check_upd("t2.sat_hi", 1'b1, 5'd7, 2'b11, 1'b0, 3'd0);
    cyc(1, 5'd7, 2'b00, 0, 0, 0);
    cyc(0, '0, 2'b00, 1, 0, 0);
    check_upd("t2.sat_lo", 1'b1, 5'd7, 2'b00, 1'b0, 3'd0);

    // Forwarding into a queued entry: 01 -> 00, then queued entry sees 00 -> 01
    cyc(1, 5'd4, 2'b01, 0, 0, 0);
    cyc(1, 5'd4, 2'b01, 0, 0, 0);
    check_eq("t3.count2", 32'(count), 32'd2);
    cyc(0, '0, 2'b00, 1, 0, 0);
    check_upd("t3.first", 1'b1, 5'd4, 2'b00, 1'b0, 3'd1);
    cyc(0, '0, 2'b00, 1, 0, 1);
    check_upd("t3.second_fwd", 1'b1, 5'd4, 2'b01, 1'b1, 3'd0);

    // Forwarding into a same-cycle push: stored as 00, not 11
    cyc(1, 5'd9, 2'b01, 0, 0, 0);
    cyc(1, 5'd9, 2'b11, 1, 0, 0);
    check_upd("t3b.first", 1'b1, 5'd9, 2'b00, 1'b0, 3'd1);
    cyc(0, '0, 2'b00, 1, 0, 0);
    check_upd("t3b.push_fwd", 1'b1, 5'd9, 2'b00, 1'b0, 3'd0);

    // Mispredict flush with a concurrent push
    cyc(1, 5'd2, 2'b10, 0, 0, 0);
    cyc(1, 5'd5, 2'b00, 0, 0, 0);
    cyc(1, 5'd6, 2'b11, 0, 0, 0);
    check_eq("t4.count3", 32'(count), 32'd3);
    set_in(1, 5'd8, 2'b01, 1, 0, 0);
    #1;
    check_eq("t4.push_ready_flush", 32'(push_ready), 32'd1);
    cyc(1, 5'd8, 2'b01, 1, 0, 0);
    check_upd("t4.flush", 1'b1, 5'd2, 2'b01, 1'b1, 3'd0);
    cyc(0, '0, 2'b00, 0, 0, 0);
    check_upd("t4.after", 1'b0, '0, 2'b00, 1'b0, 3'd0);

    // Full, ignored push, push+pop when full, wrap-around order
    cyc(1, 5'd1, 2'b00, 0, 0, 0);
    cyc(1, 5'd2, 2'b01, 0, 0, 0);
    cyc(1, 5'd3, 2'b10, 0, 0, 0);
    cyc(1, 5'd4, 2'b11, 0, 0, 0);
    check_eq("t5.full_count", 32'(count), 32'd4);
    set_in(1, 5'd5, 2'b11, 0, 0, 0);
    #1;
    check_eq("t5.push_ready_full", 32'(push_ready), 32'd0);
    cyc(1, 5'd5, 2'b11, 0, 0, 0);
    check_upd("t5.ignored", 1'b0, '0, 2'b00, 1'b0, 3'd4);
    set_in(1, 5'd6, 2'b00, 1, 0, 0);
    #1;
    check_eq("t5.push_ready_pop", 32'(push_ready), 32'd1);
    cyc(1, 5'd6, 2'b00, 1, 0, 0);
    check_upd("t5.pushpop", 1'b1, 5'd1, 2'b00, 1'b0, 3'd4);
    cyc(0, '0, 2'b00, 1, 0, 0);
    check_upd("t5.drain2", 1'b1, 5'd2, 2'b00, 1'b0, 3'd3);
    cyc(0, '0, 2'b00, 1, 1, 0);
    check_upd("t5.drain3", 1'b1, 5'd3, 2'b11, 1'b0, 3'd2);
    cyc(0, '0, 2'b00, 1, 1, 0);
    check_upd("t5.drain4", 1'b1, 5'd4, 2'b11, 1'b0, 3'd1);
    cyc(0, '0, 2'b00, 1, 0, 0);
    check_upd("t5.drain6", 1'b1, 5'd6, 2'b00, 1'b0, 3'd0);

    // Resolve while empty: no update, sticky error
    check_eq("t6.err_before", 32'(resolve_err), 32'd0);
    cyc(0, '0, 2'b00, 1, 1, 0);
    check_upd("t6.empty_res", 1'b0, '0, 2'b00, 1'b0, 3'd0);
    check_eq("t6.err_set", 32'(resolve_err), 32'd1);
    cyc(0, '0, 2'b00, 0, 0, 0);
    check_eq("t6.err_held", 32'(resolve_err), 32'd1);

    // Async reset mid-stream clears a pending write immediately
    cyc(1, 5'd10, 2'b01, 0, 0, 0);
    cyc(1, 5'd11, 2'b10, 1, 0, 0);
    check_upd("t7.pre", 1'b1, 5'd10, 2'b00, 1'b0, 3'd1);
    #2;
    arst_n = 1'b0;
    #1;
    check_upd("t7.rst", 1'b0, '0, 2'b00, 1'b0, 3'd0);
    check_eq("t7.rst_addr", 32'(upd_addr), 32'd0);
    check_eq("t7.rst_state", 32'(upd_state), 32'd0);
    check_eq("t7.rst_err", 32'(resolve_err), 32'd0);
    #3;
    arst_n = 1'b1;
    cyc(0, '0, 2'b00, 0, 0, 0);
    check_upd("t7.post", 1'b0, '0, 2'b00, 1'b0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
